pim_access_arbiter: RTL
=======================

Name: pim_access_arbiter

Overview:
- Shares the single PIM macro port (address / write data / read data) between two requesters: requester 0 is the core data port, requester 1 is the SPI debug master.
- Round-robin arbitration between the two requesters.
- One outstanding transaction at a time; the block drives a one-cycle PIM enable strobe.
- Waits a fixed read latency, then routes a response pulse back to the owning requester.
- Sits in core_top between the bus/SPI logic and the pim_addr_o/pim_wr_o/pim_rd_i pins.

Parameters:
- XLEN, 32, address and data width.
- RD_LATENCY, 2, cycles from the pim_en_o cycle until pim_rd_i is valid; legal range 1..15.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous reset, active-high.
- req0_valid_i  input  1  requester 0 request valid.
- req0_ready_o  output  1  requester 0 accepted this cycle.
- req0_we_i  input  1  1 = write, 0 = read.
- req0_addr_i  input  XLEN  address.
- req0_wdata_i  input  XLEN  write data.
- req0_rvalid_o  output  1  one-cycle response pulse.
- req0_rdata_o  output  XLEN  read data; 0 for writes.
- req1_valid_i, req1_ready_o, req1_we_i, req1_addr_i, req1_wdata_i, req1_rvalid_o, req1_rdata_o: same as requester 0, for requester 1.
- pim_en_o  output  1  PIM access strobe, one cycle per transaction.
- pim_we_o  output  1  PIM write enable; qualified by pim_en_o.
- pim_addr_o  output  XLEN  PIM address.
- pim_wd_o  output  XLEN  PIM write data.
- pim_rd_i  input  XLEN  PIM read data.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, last_grant = 1 (so requester 0 wins the first tie).
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant selection (combinational):
  - only one valid: grant it.
  - both valid: grant the requester that is not last_grant.
  - reqN_ready_o = 1 only for the granted requester, only in IDLE.
- Handshake:
  - occurs on valid & ready in cycle T.
  - latch we, addr, wdata and owner id; update last_grant to the owner; go to ISSUE.
  - ready stays 0 in every other state; requesters hold valid and payload until ready.
- ISSUE (T+1):
  - pim_en_o = 1; pim_we_o = latched we; pim_addr_o / pim_wd_o = latched values.
  - write: next state RESP.
  - read: load the latency counter with RD_LATENCY-1, next state WAIT.
  - RD_LATENCY = 1: WAIT lasts a single cycle.
- WAIT:
  - counter decrements each cycle.
  - when the counter reads 0 (cycle T+1+RD_LATENCY), capture pim_rd_i into the response register; next state RESP.
- RESP:
  - owner's rvalid_o = 1 for exactly one cycle.
  - rdata_o = captured data for reads, 0 for writes; the non-owner's rvalid stays 0.
  - next state IDLE.
- Latency from handshake cycle T:
  - read: rvalid at T+2+RD_LATENCY.
  - write: rvalid at T+2.
  - a new handshake is possible in the cycle after RESP.
- pim_addr_o / pim_wd_o hold the last latched values between transactions.
- pim_en_o and pim_we_o are 0 outside ISSUE.
- reqN_rdata_o holds its last value when rvalid is 0.
- Addresses pass through unmodified; no alignment checks.
- Requests arriving while busy are not dropped; they wait in IDLE arbitration.
- rst_i asserted in any state:
  - next cycle: IDLE, all outputs 0.
  - an in-flight transaction produces no rvalid; last_grant returns to 1.
- Fairness bound: with both requesters continuously valid, grants alternate 0,1,0,1…; neither waits more than one transaction.

Optional Feature:
- Macro PIM_ARB_PERF_EN.
- When defined:
  - adds output ports perf_cnt0_o and perf_cnt1_o, each 32 bits.
  - each counts accepted handshakes for its requester.
  - increment occurs in the handshake cycle, wraps 0xFFFF_FFFF → 0, cleared by rst_i.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single read, RD_LATENCY = 2:
  - stimulus: req0 read addr 0x0000_0100, handshake at T; pim_rd_i = 0xDEAD_BEEF at T+3.
  - required: pim_en_o = 1, pim_we_o = 0, pim_addr_o = 0x100 at T+1; req0_rvalid_o = 1 with rdata 0xDEAD_BEEF at T+4 only.
- Single write:
  - stimulus: req1 write addr 0x20, wdata 0x1234_5678.
  - required: pim_en_o = pim_we_o = 1, pim_addr_o = 0x20, pim_wd_o = 0x1234_5678 at T+1; req1_rvalid_o = 1 with rdata 0 at T+2; req0_rvalid_o stays 0.
- Simultaneous requests after reset, both held valid for 4 transactions:
  - required: grant order 0,1,0,1; each ready is a one-cycle pulse; pim_en_o strobes never overlap.
- RD_LATENCY = 1 build:
  - stimulus: read with pim_rd_i = 0xA5A5_A5A5 at T+2.
  - required: rvalid at T+3 with that data.
- Reset mid-operation:
  - stimulus: assert rst_i for one cycle during WAIT of a req0 read.
  - required: no req0_rvalid_o pulse; all outputs 0 next cycle; the next tie grants req0.
- PIM_ARB_PERF_EN build:
  - stimulus: 3 req0 and 2 req1 transactions.
  - required: perf_cnt0_o = 3, perf_cnt1_o = 2; both 0 after rst_i; a counter preloaded to 0xFFFF_FFFF wraps to 0 on the next handshake.

Source files
------------

// File: rtl/pim_access_arbiter_if.sv
// Requester ports and PIM macro pins around pim_access_arbiter; suffixes are from the arbiter's view.
// slave = arbiter side, master = requesters plus PIM macro side.
interface pim_access_arbiter_if #(
   parameter int XLEN = 32
);
   logic            req0_valid_i;
   logic            req0_ready_o;
   logic            req0_we_i;
   logic [XLEN-1:0] req0_addr_i;
   logic [XLEN-1:0] req0_wdata_i;
   logic            req0_rvalid_o;
   logic [XLEN-1:0] req0_rdata_o;

   logic            req1_valid_i;
   logic            req1_ready_o;
   logic            req1_we_i;
   logic [XLEN-1:0] req1_addr_i;
   logic [XLEN-1:0] req1_wdata_i;
   logic            req1_rvalid_o;
   logic [XLEN-1:0] req1_rdata_o;

   logic            pim_en_o;
   logic            pim_we_o;
   logic [XLEN-1:0] pim_addr_o;
   logic [XLEN-1:0] pim_wd_o;
   logic [XLEN-1:0] pim_rd_i;

   modport slave (
      input  req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
      output req0_ready_o, req0_rvalid_o, req0_rdata_o,
      input  req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
      output req1_ready_o, req1_rvalid_o, req1_rdata_o,
      output pim_en_o, pim_we_o, pim_addr_o, pim_wd_o,
      input  pim_rd_i
   );

   modport master (
      output req0_valid_i, req0_we_i, req0_addr_i, req0_wdata_i,
      input  req0_ready_o, req0_rvalid_o, req0_rdata_o,
      output req1_valid_i, req1_we_i, req1_addr_i, req1_wdata_i,
      input  req1_ready_o, req1_rvalid_o, req1_rdata_o,
      input  pim_en_o, pim_we_o, pim_addr_o, pim_wd_o,
      output pim_rd_i
   );
endinterface

// File: rtl/pim_access_arbiter.sv
// Round-robin sharing of the PIM port (req0 core, req1 SPI debug); one transaction in flight,
// response RD_LATENCY+2 cycles after a read handshake, 2 after a write; ready only while IDLE. Option: PIM_ARB_PERF_EN.
module pim_access_arbiter #(
   parameter int XLEN       = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic                clk_i,
   input  logic                rst_i,
   pim_access_arbiter_if.slave bus
`ifdef PIM_ARB_PERF_EN
   ,
   output logic [31:0]         perf_cnt0_o,
   output logic [31:0]         perf_cnt1_o
`endif
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

   state_t          state_q;
   logic            last_grant_q;
   logic            owner_q;
   logic            we_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [3:0]      cnt_q;
   logic            pim_en_q;
   logic            pim_we_q;
   logic            rvalid0_q;
   logic            rvalid1_q;
   logic [XLEN-1:0] rdata0_q;
   logic [XLEN-1:0] rdata1_q;

   logic            grant0;
   logic            grant1;
   logic            resp_fire;
   logic [XLEN-1:0] resp_dat;

   // A tie goes to whichever requester did not win last; last_grant resets to 1 so req0 wins first.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE) begin
         if (bus.req0_valid_i && bus.req1_valid_i) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
         end else begin
            grant0 = bus.req0_valid_i;
            grant1 = bus.req1_valid_i;
         end
      end
   end

   // Writes respond straight from ISSUE; reads respond once the latency counter has run out.
   always_comb begin
      resp_fire = ((state_q == ISSUE) && we_q) || ((state_q == WAIT) && (cnt_q == 4'd0));
      resp_dat  = (state_q == WAIT) ? bus.pim_rd_i : '0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= 4'd0;
         pim_en_q     <= 1'b0;
         pim_we_q     <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= '0;
         rdata1_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant0 || grant1) begin
                  owner_q      <= grant1;
                  last_grant_q <= grant1;
                  we_q         <= grant1 ? bus.req1_we_i    : bus.req0_we_i;
                  addr_q       <= grant1 ? bus.req1_addr_i  : bus.req0_addr_i;
                  wdata_q      <= grant1 ? bus.req1_wdata_i : bus.req0_wdata_i;
                  pim_en_q     <= 1'b1;
                  pim_we_q     <= grant1 ? bus.req1_we_i    : bus.req0_we_i;
                  state_q      <= ISSUE;
               end
            end
            ISSUE: begin
               pim_en_q <= 1'b0;
               pim_we_q <= 1'b0;
               if (we_q) begin
                  state_q <= RESP;
               end else begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               rvalid0_q <= 1'b0;
               rvalid1_q <= 1'b0;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         if (resp_fire) begin
            if (owner_q) begin
               rvalid1_q <= 1'b1;
               rdata1_q  <= resp_dat;
            end else begin
               rvalid0_q <= 1'b1;
               rdata0_q  <= resp_dat;
            end
         end
      end
   end

   assign bus.req0_ready_o  = grant0;
   assign bus.req1_ready_o  = grant1;
   assign bus.req0_rvalid_o = rvalid0_q;
   assign bus.req1_rvalid_o = rvalid1_q;
   assign bus.req0_rdata_o  = rdata0_q;
   assign bus.req1_rdata_o  = rdata1_q;
   assign bus.pim_en_o      = pim_en_q;
   assign bus.pim_we_o      = pim_we_q;
   assign bus.pim_addr_o    = addr_q;
   assign bus.pim_wd_o      = wdata_q;

`ifdef PIM_ARB_PERF_EN
   logic [31:0] perf_cnt0_q;
   logic [31:0] perf_cnt1_q;
   logic [31:0] perf_cnt0_d;
   logic [31:0] perf_cnt1_d;

   always_comb begin
      perf_cnt0_d = perf_cnt0_q + 32'(grant0);
      perf_cnt1_d = perf_cnt1_q + 32'(grant1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_cnt0_q <= 32'd0;
         perf_cnt1_q <= 32'd0;
      end else begin
         perf_cnt0_q <= perf_cnt0_d;
         perf_cnt1_q <= perf_cnt1_d;
      end
   end

   assign perf_cnt0_o = perf_cnt0_q;
   assign perf_cnt1_o = perf_cnt1_q;
`endif

endmodule
